// File: rtl/bit_stats_if.sv
// Handshake and result bundle between a word source, bit_stats_pipe and its consumer.
// The slave modport is the bit_stats_pipe side.
interface bit_stats_if #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 32
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] ones_cnt;
  logic [CNT_W-1:0] zeros_cnt;
  logic [CNT_W-1:0] xz_cnt;
  logic             onehot;
  logic             onehot0;
  logic             unknown;
  logic [CNT_W-1:0] clog2_val;
  logic [ACC_W-1:0] words_total;
  logic [ACC_W-1:0] ones_total;
  logic [ACC_W-1:0] unknown_total;

  modport slave (
    input  in_valid, in_data, clear, out_ready,
    output in_ready, out_valid, ones_cnt, zeros_cnt, xz_cnt, onehot, onehot0,
           unknown, clog2_val, words_total, ones_total, unknown_total
  );

  modport master (
    output in_valid, in_data, clear, out_ready,
    input  in_ready, out_valid, ones_cnt, zeros_cnt, xz_cnt, onehot, onehot0,
           unknown, clog2_val, words_total, ones_total, unknown_total
  );
endinterface

// File: rtl/bit_stats_pipe.sv
// One-stage streaming bit statistics for 4-state words, with saturating
// running totals across the accepted stream.
module bit_stats_pipe #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  bit_stats_if.slave    bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int SUM_W = ((ACC_W > CNT_W) ? ACC_W : CNT_W) + 1;
  localparam logic [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};

  logic             accept;
  logic [CNT_W-1:0] ones_n;
  logic [CNT_W-1:0] zeros_n;
  logic [CNT_W-1:0] xz_n;
  logic             unknown_n;
  logic [CNT_W-1:0] clog2_n;
  logic [WIDTH-1:0] vm1;
  logic [ACC_W-1:0] words_base;
  logic [ACC_W-1:0] ones_base;
  logic [ACC_W-1:0] unknown_base;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [SUM_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + b;
    return (s > ACC_MAX) ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Case equality keeps x/z bits out of both the ones and zeros counts.
  always_comb begin
    ones_n  = '0;
    zeros_n = '0;
    xz_n    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.in_data[i] === 1'b1)
        ones_n = ones_n + CNT_W'(1);
      else if (bus.in_data[i] === 1'b0)
        zeros_n = zeros_n + CNT_W'(1);
      else
        xz_n = xz_n + CNT_W'(1);
    end
    unknown_n = (xz_n != '0);
  end

  // ceil(log2(v)) for v >= 2 is one past the top set bit of v-1.
  always_comb begin
    clog2_n = '0;
    vm1     = '0;
    if (!unknown_n && (bus.in_data > WIDTH'(1))) begin
      vm1 = bus.in_data - WIDTH'(1);
      for (int i = 0; i < WIDTH; i++)
        if (vm1[i] == 1'b1)
          clog2_n = CNT_W'(i + 1);
    end
  end

  always_comb begin
    words_base   = bus.clear ? '0 : bus.words_total;
    ones_base    = bus.clear ? '0 : bus.ones_total;
    unknown_base = bus.clear ? '0 : bus.unknown_total;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.ones_cnt  <= '0;
      bus.zeros_cnt <= '0;
      bus.xz_cnt    <= '0;
      bus.onehot    <= 1'b0;
      bus.onehot0   <= 1'b0;
      bus.unknown   <= 1'b0;
      bus.clog2_val <= '0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.ones_cnt  <= ones_n;
      bus.zeros_cnt <= zeros_n;
      bus.xz_cnt    <= xz_n;
      bus.onehot    <= !unknown_n && (ones_n == CNT_W'(1));
      bus.onehot0   <= !unknown_n && (ones_n <= CNT_W'(1));
      bus.unknown   <= unknown_n;
      bus.clog2_val <= clog2_n;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.words_total   <= '0;
      bus.ones_total    <= '0;
      bus.unknown_total <= '0;
    end else if (accept) begin
      bus.words_total   <= sat_add(words_base, SUM_W'(1));
      bus.ones_total    <= sat_add(ones_base, SUM_W'(ones_n));
      bus.unknown_total <= sat_add(unknown_base, SUM_W'(unknown_n));
    end else begin
      bus.words_total   <= words_base;
      bus.ones_total    <= ones_base;
      bus.unknown_total <= unknown_base;
    end
  end
endmodule

// File: tb/tb_bit_stats_pipe.sv
// Directed bench for bit_stats_pipe: a 32-bit-accumulator instance plus a
// 4-bit-accumulator instance sharing the same stimulus for saturation checks.
module tb_bit_stats_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errors = 0;
  bit   four_state;

  always #5 clk = ~clk;

  bit_stats_if #(.WIDTH(16), .ACC_W(32)) bus ();
  bit_stats_if #(.WIDTH(16), .ACC_W(4))  bus4 ();

  assign bus4.in_valid  = bus.in_valid;
  assign bus4.in_data   = bus.in_data;
  assign bus4.clear     = bus.clear;
  assign bus4.out_ready = bus.out_ready;

  bit_stats_pipe #(.WIDTH(16), .ACC_W(32)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  bit_stats_pipe #(.WIDTH(16), .ACC_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  // {ones, zeros, xz, onehot, onehot0, unknown, clog2}
  wire [22:0] res = {bus.ones_cnt, bus.zeros_cnt, bus.xz_cnt, bus.onehot,
                     bus.onehot0, bus.unknown, bus.clog2_val};

  function automatic logic [4:0] ref_clog2(input logic [15:0] v);
    int n = 0;
    while ((32'd1 << n) < 32'(v)) n++;
    return 5'(n);
  endfunction

  task automatic clear_cycle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.clear    = 1'b1;
    @(negedge clk);
    bus.clear    = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({bus.out_valid, bus.in_ready, res} !== {1'b0, 1'b1, 23'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", {bus.out_valid, bus.in_ready, res}, {1'b0, 1'b1, 23'd0});
    end
    vectors++;
    if ({bus.words_total, bus.ones_total, bus.unknown_total} !== 96'd0) begin
      errors++;
      $display("FAIL reset_acc: got %h want 0", {bus.words_total, bus.ones_total, bus.unknown_total});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0010;
    @(negedge clk);
    bus.in_valid = 1'b0;
    vectors++;
    if ({bus.out_valid, res} !== {1'b1, 5'd1, 5'd15, 5'd0, 1'b1, 1'b1, 1'b0, 5'd4}) begin
      errors++;
      $display("FAIL basic_word: got %b want %b", {bus.out_valid, res}, {1'b1, 5'd1, 5'd15, 5'd0, 1'b1, 1'b1, 1'b0, 5'd4});
    end
    vectors++;
    if ({bus.words_total, bus.ones_total} !== {32'd1, 32'd1}) begin
      errors++;
      $display("FAIL basic_acc: got words %0d ones %0d want 1 1", bus.words_total, bus.ones_total);
    end
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: out_valid got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    clear_cycle();
    vectors++;
    if ({bus.words_total, bus.ones_total, bus.unknown_total} !== 96'd0) begin
      errors++;
      $display("FAIL clear_only: got %h want 0", {bus.words_total, bus.ones_total, bus.unknown_total});
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0000;
    @(negedge clk);
    bus.in_data  = 16'h0011;
    vectors++;
    if (res !== {5'd0, 5'd16, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL b2b_0000: got %b want %b", res, {5'd0, 5'd16, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0});
    end
    @(negedge clk);
    bus.in_data  = 16'hFFFF;
    vectors++;
    if (res !== {5'd2, 5'd14, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5}) begin
      errors++;
      $display("FAIL b2b_0011: got %b want %b", res, {5'd2, 5'd14, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5});
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    vectors++;
    if (res !== {5'd16, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd16}) begin
      errors++;
      $display("FAIL b2b_ffff: got %b want %b", res, {5'd16, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd16});
    end
    vectors++;
    if ({bus.words_total, bus.ones_total} !== {32'd3, 32'd18}) begin
      errors++;
      $display("FAIL b2b_acc: got words %0d ones %0d want 3 18", bus.words_total, bus.ones_total);
    end
  endtask

  task automatic test_unknown();
    logic [15:0] wd;
    logic [22:0] exp_res;
    logic [31:0] exp_unk;
    int          n1;
    clear_cycle();
    wd = 16'h00x1;
    bus.in_valid = 1'b1;
    bus.in_data  = wd;
    if (four_state) begin
      exp_res = {5'd1, 5'd11, 5'd4, 1'b0, 1'b0, 1'b1, 5'd0};
      exp_unk = 32'd1;
    end else begin
      // A 2-state simulator folds the x nibble to a known value.
      n1      = $countones(wd);
      exp_res = {5'(n1), 5'(16 - n1), 5'd0, (n1 == 1), (n1 <= 1), 1'b0, ref_clog2(wd)};
      exp_unk = 32'd0;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 16'hxxxx;
    vectors++;
    if (res !== exp_res) begin
      errors++;
      $display("FAIL unknown_word: got %b want %b", res, exp_res);
    end
    vectors++;
    if (bus.unknown_total !== exp_unk) begin
      errors++;
      $display("FAIL unknown_total: got %0d want %0d", bus.unknown_total, exp_unk);
    end
    @(negedge clk);
    vectors++;
    if ({res, bus.words_total} !== {exp_res, 32'd1}) begin
      errors++;
      $display("FAIL idle_x_ignored: got %b/%0d want %b/1", res, bus.words_total, exp_res);
    end
  endtask

  task automatic test_backpressure();
    clear_cycle();
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h0005;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_data   = 16'h0300;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if ({bus.in_ready, bus.out_valid, res, bus.words_total, bus.ones_total} !==
          {1'b0, 1'b1, 5'd2, 5'd14, 5'd0, 1'b0, 1'b0, 1'b0, 5'd3, 32'd1, 32'd2}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: rdy %b vld %b res %b words %0d ones %0d want 0 1 %b 1 2", i,
                 bus.in_ready, bus.out_valid, res, bus.words_total, bus.ones_total,
                 {5'd2, 5'd14, 5'd0, 1'b0, 1'b0, 1'b0, 5'd3});
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %b want 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    vectors++;
    if ({res, bus.words_total, bus.ones_total} !==
        {5'd2, 5'd14, 5'd0, 1'b0, 1'b0, 1'b0, 5'd10, 32'd2, 32'd4}) begin
      errors++;
      $display("FAIL bp_next_word: got %b words %0d ones %0d want %b 2 4", res,
               bus.words_total, bus.ones_total, {5'd2, 5'd14, 5'd0, 1'b0, 1'b0, 1'b0, 5'd10});
    end
  endtask

  task automatic test_saturation();
    clear_cycle();
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hFFFF;
    @(negedge clk);
    vectors++;
    if ({bus4.words_total, bus4.ones_total} !== {4'd1, 4'd15}) begin
      errors++;
      $display("FAIL sat_first: got words %0d ones %0d want 1 15", bus4.words_total, bus4.ones_total);
    end
    bus.in_data = 16'h0001;
    @(negedge clk);
    vectors++;
    if ({bus4.words_total, bus4.ones_total} !== {4'd2, 4'd15}) begin
      errors++;
      $display("FAIL sat_hold: got words %0d ones %0d want 2 15", bus4.words_total, bus4.ones_total);
    end
    bus.in_data = 16'h0003;
    bus.clear   = 1'b1;
    @(negedge clk);
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    vectors++;
    if ({bus4.words_total, bus4.ones_total, bus4.unknown_total, bus4.clog2_val} !==
        {4'd1, 4'd2, 4'd0, 5'd2}) begin
      errors++;
      $display("FAIL clear_with_accept: got words %0d ones %0d unk %0d clog2 %0d want 1 2 0 2",
               bus4.words_total, bus4.ones_total, bus4.unknown_total, bus4.clog2_val);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h0007;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    vectors++;
    if (!(bus.out_valid === 1'b1 && bus.words_total !== 32'd0)) begin
      errors++;
      $display("FAIL rst_mid_setup: out_valid %b words %0d want 1 and nonzero", bus.out_valid, bus.words_total);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.out_valid, bus.in_ready, res, bus.words_total, bus.ones_total, bus.unknown_total} !==
        {1'b0, 1'b1, 23'd0, 96'd0}) begin
      errors++;
      $display("FAIL rst_mid_async: vld %b rdy %b res %b acc %h want 0 1 0 0",
               bus.out_valid, bus.in_ready, res, {bus.words_total, bus.ones_total, bus.unknown_total});
    end
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h0010;
    @(negedge clk);
    bus.in_valid = 1'b0;
    vectors++;
    if ({res, bus.words_total, bus.ones_total} !==
        {5'd1, 5'd15, 5'd0, 1'b1, 1'b1, 1'b0, 5'd4, 32'd1, 32'd1}) begin
      errors++;
      $display("FAIL rst_first_accept: got %b words %0d ones %0d", res, bus.words_total, bus.ones_total);
    end
  endtask

  initial begin
    logic [1:0] probe;
    probe = 2'bx0;
    four_state = (probe[1] === 1'bx);
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0000;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_unknown();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/bit_stats_pipe.md
# bit_stats_pipe

Streaming, parametrised successor to the combinational bit-vector math coverage blocks. It accepts one 4-state word per valid/ready handshake and registers per-word statistics: ones/zeros/x-z counts, one-hot flags, unknown flag and ceiling-log2. It also keeps saturating running totals across the stream. It sits in the coverage/checker datapath between a word source and a scoreboard, adding one register stage of latency and full backpressure.

## Interface
- WIDTH, 16: input word width, ≥ 2.
- ACC_W, 32: width of the running accumulators, ≥ 4.
- CNT_W, $clog2(WIDTH+1): derived, not overridden. Width of per-word count and clog2 fields.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is offered.
- in_ready  output  1  block can accept. Equals `!out_valid || out_ready`, combinational.
- in_data  input  WIDTH  4-state word under analysis.
- clear  input  1  synchronous clear of the accumulators.
- out_valid  output  1  per-word result registers hold a valid result.
- out_ready  input  1  consumer accepts the result.
- ones_cnt  output  CNT_W  number of bits equal to 1.
- zeros_cnt  output  CNT_W  number of bits equal to 0.
- xz_cnt  output  CNT_W  number of bits that are x or z.
- onehot  output  1  exactly one bit is 1 and no bits are x/z.
- onehot0  output  1  at most one bit is 1 and no bits are x/z.
- unknown  output  1  at least one bit is x/z.
- clog2_val  output  CNT_W  ceil(log2(in_data)) for known words; 0 when unknown.
- words_total  output  ACC_W  number of accepted words, saturating.
- ones_total  output  ACC_W  sum of ones_cnt over accepted words, saturating.
- unknown_total  output  ACC_W  number of accepted words with the unknown flag set, saturating.

## Operation
- Accept a word when `in_valid && in_ready`.
- On accept, the per-word results for in_data are registered and out_valid is set.
- While `out_valid && !out_ready`:
  - in_ready = 0.
  - All result outputs are held stable.
- When out_valid = 1, out_ready = 1 and no accept happens in the same cycle, out_valid is cleared.
- Counts: `ones_cnt + zeros_cnt + xz_cnt == WIDTH` always.
- x/z bits contribute only to xz_cnt.
- clog2_val rules:
  - Smallest n such that 2^n ≥ value.
  - clog2(0) = 0 and clog2(1) = 0.
  - Maximum is WIDTH, for values above 2^(WIDTH-1).
  - Forced to 0 when unknown = 1.
- Accumulators update only on accept:
  - words_total += 1.
  - ones_total += ones_cnt.
  - unknown_total += unknown.
  - Each accumulator saturates at 2^ACC_W − 1 and never wraps.
- clear sets all three accumulators to 0 in the next cycle.
- clear and accept in the same cycle: the accumulators take the accepted word's contribution only (clear first, then add).
- clear does not affect out_valid or the per-word result registers.
- clear asserted with no accept: accumulators go to 0.

## Timing
- Latency: word accepted at edge k → results visible after edge k, with out_valid = 1 in cycle k+1.
- Accumulators reflect the word after the same edge.
- Throughput: one word per cycle when out_ready is held at 1.
- Reset (rst_n low, asynchronous):
  - out_valid = 0.
  - All count, flag, clog2 and accumulator outputs = 0.
  - in_ready = 1, derived from out_valid = 0.
- Reset mid-stream: any pending result is discarded.
- First accept after rst_n rises is processed normally.
- in_data must be sampled only on accept; x/z on in_data when not accepting has no effect.

## Test plan
- Basic word: WIDTH=16, accept 16'h0010. Required next cycle:
  - ones_cnt=1, zeros_cnt=15, xz_cnt=0.
  - onehot=1, onehot0=1, unknown=0.
  - clog2_val=4.
  - words_total=1, ones_total=1.
- Boundary values, accepted back-to-back: 16'h0000, 16'h0011, 16'hFFFF. Required per cycle:
  - 16'h0000: clog2_val 0, onehot 0, onehot0 1.
  - 16'h0011: clog2_val 5.
  - 16'hFFFF: clog2_val 16, ones_cnt 16.
  - Then ones_total=18, words_total=3.
- Unknown word: accept 16'h00x1 (one nibble x). Required:
  - xz_cnt=4, ones_cnt=1, zeros_cnt=11.
  - unknown=1, onehot=0, onehot0=0, clog2_val=0.
  - unknown_total=1.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1. Required:
  - in_ready=0 and results stable throughout.
  - Accumulators unchanged.
  - Raising out_ready accepts the next word in the same cycle.
- Saturation and clear: ACC_W=4, accept 16'hFFFF then 16'h0001. Required:
  - ones_total=15 (saturated), words_total=2.
  - Then clear together with an accept of 16'h0003: ones_total=2, words_total=1, unknown_total=0.
- Reset mid-operation: drop rst_n while out_valid=1 and the accumulators are non-zero. Required:
  - All outputs 0 immediately, without waiting for a clock edge.
  - in_ready=1.
